// File: rtl/ascii_pkg.sv
// Shared types and default geometry for the ASCII shader tile gather.
package ascii_pkg;

  localparam int DEF_COLORS      = 3;
  localparam int DEF_COLOR_DEPTH = 8;
  localparam int PIXEL_W         = DEF_COLORS * DEF_COLOR_DEPTH;
  localparam int DEF_WIDTH       = 640;
  localparam int DEF_HEIGHT      = 480;
  localparam int DEF_TILE_W      = 8;
  localparam int DEF_TILE_H      = 8;
  localparam int TILES_X         = DEF_WIDTH / DEF_TILE_W;
  localparam int TILES_Y         = DEF_HEIGHT / DEF_TILE_H;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [DEF_TILE_W-1:0][DEF_TILE_H-1:0] tile_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_READ,
    D_PRESENT
  } drain_state_e;

endpackage

// File: rtl/ascii_stripe_bank.sv
// One stripe bank: TILE_HEIGHT rows of tile-row words, write port plus registered read port.
module ascii_stripe_bank #(
  parameter int WORD_W = 192,
  parameter int DEPTH  = 640,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ascii_tile_gather.sv
// Regroups a raster pixel stream into tiles using two ping-pong stripe banks.
//   state     | meaning
//   D_IDLE    | waiting for the drain bank to fill; prefetches row 0 when it does
//   D_READ    | one row read per cycle into tile_out, last row captured -> present
//   D_PRESENT | tile_valid high, outputs held until tile_ready
module ascii_tile_gather
  import ascii_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int TILE_WIDTH  = DEF_TILE_W,
  parameter int TILE_HEIGHT = DEF_TILE_H,
  parameter int COLORS      = DEF_COLORS,
  parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
  parameter int DATA_WIDTH  = COLORS * COLOR_DEPTH,
  localparam int XW         = $clog2(WIDTH / TILE_WIDTH),
  localparam int YW         = $clog2(HEIGHT / TILE_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  pixel_sof,
  output logic                  pixel_ready,
  output logic [TILE_WIDTH-1:0][TILE_HEIGHT-1:0][DATA_WIDTH-1:0] tile_out,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output logic [XW-1:0]         tile_x,
  output logic [YW-1:0]         tile_y,
  output logic                  frame_err
);

  localparam int COLS   = WIDTH / TILE_WIDTH;
  localparam int ROWS   = HEIGHT / TILE_HEIGHT;
  localparam int WORD_W = TILE_WIDTH * DATA_WIDTH;
  localparam int DEPTH  = TILE_HEIGHT * COLS;
  localparam int AW     = $clog2(DEPTH);
  localparam int PXW    = $clog2(WIDTH);
  localparam int PYW    = $clog2(TILE_HEIGHT);
  localparam int RW     = $clog2(TILE_HEIGHT + 1);

  logic [PXW-1:0]    px, px_eff;
  logic [PYW-1:0]    py, py_eff;
  logic [YW-1:0]     stripe, stripe_eff;
  logic [1:0]        bank_full, set_full, clr_full;
  logic              fill_bank, drain_bank;
  logic [WORD_W-1:0] sr, word, rdata0, rdata1, rd_word;
  logic              hs, sof_err, wr_en, row_end, stripe_end;
  logic [AW-1:0]     waddr, raddr;

  drain_state_e      state, state_nxt;
  logic [RW-1:0]     r, r_nxt;
  logic [PYW-1:0]    cap_row;
  logic              re, rd_pend, cap_en, accept, bank_rel, last_col;

  assign pixel_ready = !bank_full[fill_bank];
  assign hs          = pixel_valid && pixel_ready;
  assign sof_err     = hs && pixel_sof && (px != '0 || py != '0 || stripe != '0);

  // An unexpected SOF restarts the fill at (0,0) of stripe 0 in the current bank.
  always_comb begin
    px_eff     = sof_err ? '0 : px;
    py_eff     = sof_err ? '0 : py;
    stripe_eff = sof_err ? '0 : stripe;
  end

  assign word       = {pixel_in, sr[WORD_W-1:DATA_WIDTH]};
  assign wr_en      = hs && ((int'(px_eff) % TILE_WIDTH) == TILE_WIDTH - 1);
  assign waddr      = AW'(int'(py_eff) * COLS + int'(px_eff) / TILE_WIDTH);
  assign row_end    = int'(px_eff) == WIDTH - 1;
  assign stripe_end = hs && row_end && (int'(py_eff) == TILE_HEIGHT - 1);
  assign set_full   = stripe_end ? (fill_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_full   = bank_rel ? (drain_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      px        <= '0;
      py        <= '0;
      stripe    <= '0;
      fill_bank <= 1'b0;
      sr        <= '0;
      frame_err <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      frame_err <= sof_err;
      bank_full <= (bank_full | set_full) & ~clr_full;
      if (hs) begin
        sr     <= word;
        stripe <= stripe_eff;
        if (row_end) begin
          px <= '0;
          py <= (int'(py_eff) == TILE_HEIGHT - 1) ? '0 : py_eff + PYW'(1);
        end else begin
          px <= px_eff + PXW'(1);
          py <= py_eff;
        end
        if (stripe_end) begin
          fill_bank <= ~fill_bank;
          stripe    <= (int'(stripe_eff) == ROWS - 1) ? '0 : stripe_eff + YW'(1);
        end
      end
    end
  end

  ascii_stripe_bank #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_bank0 (
    .clk(clk), .we(wr_en && !fill_bank), .waddr(waddr), .wdata(word),
    .re(re && !drain_bank), .raddr(raddr), .rdata(rdata0)
  );

  ascii_stripe_bank #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_bank1 (
    .clk(clk), .we(wr_en && fill_bank), .waddr(waddr), .wdata(word),
    .re(re && drain_bank), .raddr(raddr), .rdata(rdata1)
  );

  assign rd_word    = drain_bank ? rdata1 : rdata0;
  assign raddr      = AW'(int'(r) * COLS + int'(tile_x));
  assign last_col   = int'(tile_x) == COLS - 1;
  assign tile_valid = (state == D_PRESENT);

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    re        = 1'b0;
    cap_en    = 1'b0;
    accept    = 1'b0;
    bank_rel  = 1'b0;
    case (state)
      D_IDLE: begin
        if (bank_full[drain_bank]) begin
          re        = 1'b1;
          r_nxt     = RW'(1);
          state_nxt = D_READ;
        end
      end
      D_READ: begin
        if (int'(r) < TILE_HEIGHT) begin
          re    = 1'b1;
          r_nxt = r + RW'(1);
        end
        if (rd_pend) begin
          cap_en = 1'b1;
          if (int'(cap_row) == TILE_HEIGHT - 1) begin
            state_nxt = D_PRESENT;
            r_nxt     = '0;
          end
        end
      end
      D_PRESENT: begin
        if (tile_ready) begin
          accept    = 1'b1;
          bank_rel  = last_col;
          state_nxt = last_col ? D_IDLE : D_READ;
        end
      end
      default: state_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= D_IDLE;
      r          <= '0;
      rd_pend    <= 1'b0;
      cap_row    <= '0;
      tile_x     <= '0;
      tile_y     <= '0;
      drain_bank <= 1'b0;
      tile_out   <= '0;
    end else begin
      state   <= state_nxt;
      r       <= r_nxt;
      rd_pend <= re;
      if (re) cap_row <= r[PYW-1:0];
      if (cap_en) begin
        for (int x = 0; x < TILE_WIDTH; x++)
          tile_out[x][cap_row] <= rd_word[x*DATA_WIDTH +: DATA_WIDTH];
      end
      if (accept) begin
        if (last_col) begin
          tile_x     <= '0;
          tile_y     <= (int'(tile_y) == ROWS - 1) ? '0 : tile_y + YW'(1);
          drain_bank <= ~drain_bank;
        end else begin
          tile_x <= tile_x + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ascii_tile_gather.sv
// Scoreboard bench for ascii_tile_gather on a 32x16 frame with 8x8 tiles.
module tb_ascii_tile_gather;

  localparam int W  = 32;
  localparam int H  = 16;
  localparam int TW = 8;
  localparam int TH = 8;

  typedef logic [TW-1:0][TH-1:0][23:0] tile_d_t;
  typedef struct {
    int      tx;
    int      ty;
    tile_d_t d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pixel_in = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_sof = 1'b0;
  logic        pixel_ready;
  tile_d_t     tile_out;
  logic        tile_valid;
  logic        tile_ready = 1'b1;
  logic [1:0]  tile_x;
  logic [0:0]  tile_y;
  logic        frame_err;

  ascii_tile_gather #(.WIDTH(W), .HEIGHT(H), .TILE_WIDTH(TW), .TILE_HEIGHT(TH)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_sof(pixel_sof), .pixel_ready(pixel_ready), .tile_out(tile_out),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_x(tile_x),
    .tile_y(tile_y), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   acc_total = 0;
  int   err_cycles = 0;
  bit   arm_lat = 0, lat_armed = 0, acc_valid = 0, drop_chk = 0;
  int   lat_ref = 0, acc_cyc = 0;
  bit   f_done = 0;

  function automatic logic [23:0] pix(input int x, input int y);
    return {8'h00, 8'(y), 8'(x)};
  endfunction

  function automatic tile_d_t mk_tile(input int tx, input int ty);
    tile_d_t d;
    for (int c = 0; c < TW; c++)
      for (int r = 0; r < TH; r++)
        d[c][r] = pix(tx * TW + c, ty * TH + r);
    return d;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int ty = 0; ty < H / TH; ty++)
      for (int tx = 0; tx < W / TW; tx++) begin
        e.tx = tx;
        e.ty = ty;
        e.d  = mk_tile(tx, ty);
        sb.push_back(e);
      end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_tile(input exp_t e);
    n_vec++;
    if (int'(tile_x) != e.tx || int'(tile_y) != e.ty || tile_out !== e.d) begin
      int fc = 0, fr = 0;
      bit found = 0;
      for (int c = 0; c < TW; c++)
        for (int r = 0; r < TH; r++)
          if (!found && tile_out[c][r] !== e.d[c][r]) begin
            found = 1; fc = c; fr = r;
          end
      n_err++;
      $display("FAIL tile(%0d,%0d): got coord (%0d,%0d) pix[%0d][%0d]=%06h, expected %06h",
               e.tx, e.ty, tile_x, tile_y, fc, fr, tile_out[fc][fr], e.d[fc][fr]);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted tile and checks timing.
  initial begin
    bit   tv_q;
    exp_t e;
    tv_q = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tv_q = 0; acc_valid = 0; drop_chk = 0;
        continue;
      end
      if (frame_err) err_cycles++;
      if (drop_chk) begin
        drop_chk = 0;
        check("valid_drop", {31'd0, tile_valid}, 32'd0);
      end
      if (tile_valid && !tv_q) begin
        if (lat_armed) begin
          lat_armed = 0;
          check("first_latency", cyc - lat_ref, TH + 1);
        end
        if (acc_valid) begin
          acc_valid = 0;
          check("next_latency", cyc - acc_cyc, TH + 1);
        end
      end
      tv_q = tile_valid;
      if (tile_valid && tile_ready) begin
        acc_total++;
        acc_cyc   = cyc + 1;
        acc_valid = (tile_x != 2'd3);
        drop_chk  = 1;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_tile: got tile (%0d,%0d), expected none", tile_x, tile_y);
        end else begin
          e = sb.pop_front();
          compare_tile(e);
        end
      end
    end
  end

  task automatic send_pix(input logic [23:0] d, input bit sof, input bit rnd);
    int guard;
    if (rnd) while ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    pixel_in = d; pixel_sof = sof; pixel_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (pixel_ready) break;
      guard++;
      if (guard > 4000) begin
        n_vec++; n_err++;
        $display("FAIL pixel_stall: got no pixel_ready for %0d cycles, expected accept", guard);
        break;
      end
    end
    @(posedge clk); #1;
    pixel_valid = 1'b0; pixel_sof = 1'b0;
  endtask

  task automatic send_frame(input bit rnd);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        send_pix(pix(x, y), (x == 0 && y == 0), rnd);
        if (arm_lat && x == W - 1 && y == TH - 1) begin
          lat_ref = cyc; lat_armed = 1; arm_lat = 0;
        end
      end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || tile_valid) && g < 3000) begin @(posedge clk); #1; g++; end
    if (g >= 3000) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d tiles outstanding, expected 0", sb.size());
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pixel_ready"}, {31'd0, pixel_ready}, 32'd1);
    check({tag, "_tile_valid"}, {31'd0, tile_valid}, 32'd0);
    check({tag, "_tile_out"}, {31'd0, (tile_out == '0)}, 32'd1);
    check({tag, "_tile_x"}, {30'd0, tile_x}, 32'd0);
    check({tag, "_tile_y"}, {31'd0, tile_y}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;

    // 1: continuous frame, ready tied high
    push_frame();
    arm_lat = 1;
    send_frame(0);
    wait_drain();
    check("sof_no_err", err_cycles, 32'd0);

    // 2: back-pressure stalls input, held tile stays stable
    f_done = 0;
    fork
      begin
        push_frame(); send_frame(0); f_done = 1;
        push_frame(); send_frame(0);
      end
      begin
        int a0 = acc_total;
        int g = 0;
        bit st = 1;
        while (acc_total == a0 && g < 5000) begin @(posedge clk); #1; g++; end
        tile_ready = 1'b0;
        g = 0;
        while (!f_done && g < 5000) begin @(posedge clk); #1; g++; end
        repeat (2) @(negedge clk);
        check("stall_ready", {31'd0, pixel_ready}, 32'd0);
        repeat (50) begin
          @(negedge clk);
          if (!tile_valid || sb.size() == 0 || tile_out !== sb[0].d || int'(tile_x) != sb[0].tx)
            st = 0;
        end
        check("hold_stable", {31'd0, st}, 32'd1);
        @(posedge clk); #1;
        tile_ready = 1'b1;
      end
    join
    wait_drain();

    // 3: random valid and ready
    f_done = 0;
    fork
      begin push_frame(); send_frame(1); f_done = 1; end
      begin
        int g = 0;
        while (!(f_done && sb.size() == 0) && g < 20000) begin
          @(posedge clk); #1;
          tile_ready = 1'($urandom_range(0, 1));
          g++;
        end
        tile_ready = 1'b1;
      end
    join
    wait_drain();

    // 4: unexpected SOF at (5,3) of stripe 0
    check("err_before_sof", err_cycles, 32'd0);
    for (int y = 0; y <= 3; y++)
      for (int x = 0; x < W; x++)
        if (y < 3 || x < 5) send_pix(pix(x, y), (x == 0 && y == 0), 0);
    push_frame();
    send_frame(0);
    wait_drain();
    check("sof_err_pulse", err_cycles, 32'd1);

    // 5: reset while draining stripe 0
    for (int y = 0; y < TH; y++)
      for (int x = 0; x < W; x++)
        send_pix(pix(x, y), (x == 0 && y == 0), 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check_reset("midrst");

    // 6: back-to-back frames, coordinates wrap
    push_frame();
    push_frame();
    send_frame(0);
    send_frame(0);
    wait_drain();

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
